painterengine_gpu_dma_writer: RTL

AXI4 write master for the GPU DMA path: drains 32-bit words from one of four routed producer channels and writes them to memory.
- Each burst is at most 256 beats and never crosses a 1 KB boundary.
- It is the write-direction counterpart of the GPU DMA reader and shares its routing, error-code and timeout conventions.
- One-shot per reset: done/error are sticky until i_wire_resetn is asserted.

---
 rtl/painterengine_gpu_dma_writer.sv | 278 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/painterengine_gpu_dma_writer.sv
// AXI4 write master for the GPU DMA path: drains one routed producer channel into memory
// in INCR bursts of at most 256 beats that never cross a 1 KB boundary.
// Optional beat counter output: define PAINTERENGINE_GPU_DMA_WRITER_PROGRESS_EN.
module painterengine_gpu_dma_writer #(
    parameter int TIMEOUT_BIT = 18
) (
    input  logic         i_wire_clock,
    input  logic         i_wire_resetn,
    output logic         o_wire_done,
    input  logic [127:0] i_wire_address,
    input  logic [127:0] i_wire_length,
    input  logic [3:0]   i_wire_router,
    input  logic [127:0] i_wire_data,
    input  logic [3:0]   i_wire_data_valid,
    output logic [3:0]   o_wire_data_next,
    output logic         o_wire_error,
    output logic [2:0]   o_wire_error_type,
`ifdef PAINTERENGINE_GPU_DMA_WRITER_PROGRESS_EN
    output logic [31:0]  o_wire_progress,
`endif
    output logic         o_wire_M_AXI_AWID,
    output logic [31:0]  o_wire_M_AXI_AWADDR,
    output logic [7:0]   o_wire_M_AXI_AWLEN,
    output logic [2:0]   o_wire_M_AXI_AWSIZE,
    output logic [1:0]   o_wire_M_AXI_AWBURST,
    output logic         o_wire_M_AXI_AWLOCK,
    output logic [3:0]   o_wire_M_AXI_AWCACHE,
    output logic [2:0]   o_wire_M_AXI_AWPROT,
    output logic [3:0]   o_wire_M_AXI_AWQOS,
    output logic         o_wire_M_AXI_AWVALID,
    input  logic         i_wire_M_AXI_AWREADY,
    output logic [31:0]  o_wire_M_AXI_WDATA,
    output logic [3:0]   o_wire_M_AXI_WSTRB,
    output logic         o_wire_M_AXI_WLAST,
    output logic         o_wire_M_AXI_WVALID,
    input  logic         i_wire_M_AXI_WREADY,
    input  logic         i_wire_M_AXI_BID,
    input  logic [1:0]   i_wire_M_AXI_BRESP,
    input  logic         i_wire_M_AXI_BVALID,
    output logic         o_wire_M_AXI_BREADY
);

    typedef enum logic [3:0] {
        ST_ROUTING     = 4'd0,
        ST_PARAM_CHECK = 4'd1,
        ST_CALC1       = 4'd2,
        ST_CALC2       = 4'd3,
        ST_ADDR        = 4'd4,
        ST_DATA        = 4'd5,
        ST_RESP        = 4'd6,
        ST_DONE        = 4'd7,
        ST_ERROR       = 4'd8
    } state_t;

    localparam logic [2:0] ERR_OK       = 3'd0;
    localparam logic [2:0] ERR_ROUTER   = 3'd1;
    localparam logic [2:0] ERR_ADDRESS  = 3'd2;
    localparam logic [2:0] ERR_AW_TMO   = 3'd3;
    localparam logic [2:0] ERR_W_TMO    = 3'd4;
    localparam logic [2:0] ERR_PROTOCOL = 3'd5;
    localparam logic [2:0] ERR_BRESP    = 3'd6;
    localparam logic [2:0] ERR_B_TMO    = 3'd7;

    localparam int TMO_W = TIMEOUT_BIT + 1;

    state_t             state_q, state_d;
    logic [31:0]        address_q, address_d;
    logic [31:0]        length_q, length_d;
    logic [31:0]        offset_q, offset_d;
    logic [31:0]        remaining_q, remaining_d;
    logic [7:0]         unalign_q, unalign_d;
    logic [8:0]         aligned_q, aligned_d;
    logic [8:0]         beat_q, beat_d;
    logic [1:0]         idx_q, idx_d;
    logic [TMO_W-1:0]   timeout_q, timeout_d;
    logic [2:0]         error_type_q, error_type_d;
`ifdef PAINTERENGINE_GPU_DMA_WRITER_PROGRESS_EN
    logic [31:0]        progress_q, progress_d;
`endif

    logic [8:0] burst;
    logic [8:0] burst_m1;
    logic       w_valid;
    logic       aw_hs;
    logic       w_hs;
    logic       b_hs;
    logic       route_ok;
    logic [1:0] route_idx;

    // Burst length is bounded both by the words left and by the distance to the next 1 KB line.
    assign burst    = (remaining_q < {23'd0, aligned_q}) ? remaining_q[8:0] : aligned_q;
    assign burst_m1 = burst - 9'd1;
    assign w_valid  = (state_q == ST_DATA) && i_wire_data_valid[idx_q];
    assign aw_hs    = (state_q == ST_ADDR) && i_wire_M_AXI_AWREADY;
    assign w_hs     = w_valid && i_wire_M_AXI_WREADY;
    assign b_hs     = (state_q == ST_RESP) && i_wire_M_AXI_BVALID;

    // NOTE: sequential state uses non-blocking assignments only; all next values come from always_comb.
    always_ff @(posedge i_wire_clock or negedge i_wire_resetn) begin
        if (!i_wire_resetn) begin
            state_q      <= ST_ROUTING;
            address_q    <= '0;
            length_q     <= '0;
            offset_q     <= '0;
            remaining_q  <= '0;
            unalign_q    <= '0;
            aligned_q    <= '0;
            beat_q       <= '0;
            idx_q        <= '0;
            timeout_q    <= '0;
            error_type_q <= ERR_OK;
`ifdef PAINTERENGINE_GPU_DMA_WRITER_PROGRESS_EN
            progress_q   <= '0;
`endif
        end else begin
            state_q      <= state_d;
            address_q    <= address_d;
            length_q     <= length_d;
            offset_q     <= offset_d;
            remaining_q  <= remaining_d;
            unalign_q    <= unalign_d;
            aligned_q    <= aligned_d;
            beat_q       <= beat_d;
            idx_q        <= idx_d;
            timeout_q    <= timeout_d;
            error_type_q <= error_type_d;
`ifdef PAINTERENGINE_GPU_DMA_WRITER_PROGRESS_EN
            progress_q   <= progress_d;
`endif
        end
    end

    // NOTE: every signal written below gets a default first so no latch can be inferred.
    always_comb begin
        state_d      = state_q;
        address_d    = address_q;
        length_d     = length_q;
        offset_d     = offset_q;
        remaining_d  = remaining_q;
        unalign_d    = unalign_q;
        aligned_d    = aligned_q;
        beat_d       = beat_q;
        idx_d        = idx_q;
        error_type_d = error_type_q;
        route_ok     = 1'b1;
        route_idx    = 2'd0;

        case (i_wire_router)
            4'b0001: route_idx = 2'd0;
            4'b0010: route_idx = 2'd1;
            4'b0100: route_idx = 2'd2;
            4'b1000: route_idx = 2'd3;
            default: route_ok  = 1'b0;
        endcase

        case (state_q)
            ST_ROUTING: begin
                if (route_ok) begin
                    idx_d     = route_idx;
                    address_d = i_wire_address[{route_idx, 5'd0} +: 32];
                    length_d  = i_wire_length[{route_idx, 5'd0} +: 32];
                    state_d   = ST_PARAM_CHECK;
                end else begin
                    error_type_d = ERR_ROUTER;
                    state_d      = ST_ERROR;
                end
            end
            ST_PARAM_CHECK: begin
                if ((address_q[1:0] != 2'b00) || (length_q == 32'd0)) begin
                    error_type_d = ERR_ADDRESS;
                    state_d      = ST_ERROR;
                end else begin
                    offset_d = '0;
                    beat_d   = '0;
                    state_d  = ST_CALC1;
                end
            end
            ST_CALC1: begin
                unalign_d = address_q[9:2] + offset_q[7:0];
                state_d   = ST_CALC2;
            end
            ST_CALC2: begin
                remaining_d = length_q - offset_q;
                aligned_d   = 9'd256 - {1'b0, unalign_q};
                state_d     = ST_ADDR;
            end
            ST_ADDR: begin
                if (aw_hs) begin
                    beat_d  = '0;
                    state_d = ST_DATA;
                end else if (timeout_q[TIMEOUT_BIT]) begin
                    error_type_d = ERR_AW_TMO;
                    state_d      = ST_ERROR;
                end
            end
            ST_DATA: begin
                if (w_hs) begin
                    beat_d = beat_q + 9'd1;
                    if (beat_q == burst_m1) begin
                        offset_d = offset_q + {23'd0, burst};
                        state_d  = ST_RESP;
                    end
                end else if (timeout_q[TIMEOUT_BIT]) begin
                    error_type_d = ERR_W_TMO;
                    state_d      = ST_ERROR;
                end
            end
            ST_RESP: begin
                if (b_hs) begin
                    if (i_wire_M_AXI_BRESP != 2'b00) begin
                        error_type_d = ERR_BRESP;
                        state_d      = ST_ERROR;
                    end else if (offset_q >= length_q) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_CALC1;
                    end
                end else if (timeout_q[TIMEOUT_BIT]) begin
                    error_type_d = ERR_B_TMO;
                    state_d      = ST_ERROR;
                end
            end
            default: ;
        endcase

        // A write response nobody asked for means the interconnect and this master disagree.
        if (i_wire_M_AXI_BVALID && (state_q != ST_RESP) &&
            (state_q != ST_DONE) && (state_q != ST_ERROR)) begin
            error_type_d = ERR_PROTOCOL;
            state_d      = ST_ERROR;
        end

        if ((state_d != state_q) || aw_hs || w_hs || b_hs)
            timeout_d = '0;
        else if ((state_q == ST_ADDR) || (state_q == ST_DATA) || (state_q == ST_RESP))
            timeout_d = timeout_q + TMO_W'(1);
        else
            timeout_d = timeout_q;

`ifdef PAINTERENGINE_GPU_DMA_WRITER_PROGRESS_EN
        progress_d = w_hs ? progress_q + 32'd1 : progress_q;
`endif
    end

    always_comb begin
        o_wire_done          = (state_q == ST_DONE);
        o_wire_error         = (state_q == ST_ERROR);
        o_wire_error_type    = error_type_q;
        o_wire_M_AXI_AWVALID = (state_q == ST_ADDR);
        o_wire_M_AXI_AWADDR  = address_q + {offset_q[29:0], 2'b00};
        o_wire_M_AXI_AWLEN   = burst_m1[7:0];
        o_wire_M_AXI_WVALID  = w_valid;
        o_wire_M_AXI_WDATA   = i_wire_data[{idx_q, 5'd0} +: 32];
        o_wire_M_AXI_WLAST   = (state_q == ST_DATA) && (beat_q == burst_m1);
        o_wire_M_AXI_BREADY  = (state_q == ST_RESP);
        o_wire_data_next     = 4'b0000;
        if (w_hs)
            o_wire_data_next[idx_q] = 1'b1;
    end

    assign o_wire_M_AXI_AWID    = 1'b0;
    assign o_wire_M_AXI_AWSIZE  = 3'b010;
    assign o_wire_M_AXI_AWBURST = 2'b01;
    assign o_wire_M_AXI_AWLOCK  = 1'b0;
    assign o_wire_M_AXI_AWCACHE = 4'b0010;
    assign o_wire_M_AXI_AWPROT  = 3'b000;
    assign o_wire_M_AXI_AWQOS   = 4'b0000;
    assign o_wire_M_AXI_WSTRB   = 4'hF;

`ifdef PAINTERENGINE_GPU_DMA_WRITER_PROGRESS_EN
    assign o_wire_progress = progress_q;
`endif

    // BID is single-ID and the top offset bits fall off the byte-address shift.
    logic unused_ok;
    assign unused_ok = &{1'b0, i_wire_M_AXI_BID, offset_q[31:30]};

endmodule
